// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: shares one resource among 2**N requesters.
// A grant is held until the owner signals done, drops its request, or
// reaches MAX_HOLD cycles. Each release is followed by at least one idle
// cycle before the next grant.
//
// state | meaning
// IDLE  | no owner; arbitrate on req starting from the rotating pointer
// BUSY  | grant_idx owns the resource; watch for done, request drop, or hold limit
module rr_grant_scheduler #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [0:2**N-1] req,
    input  logic            done,
    output logic [0:2**N-1] grant,
    output logic [N-1:0]    grant_idx,
    output logic            grant_valid
);

    localparam int NR  = 2**N;
    localparam int CW  = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [0:NR-1]   grant_q, grant_d;
    logic [N-1:0]    idx_q, idx_d;
    logic            valid_q, valid_d;
    logic [N-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [N-1:0]    cand;
    logic [N-1:0]    win;
    logic            found;
    logic            hold_limit;
    logic            rel_now;

    // The hold limit is disabled when MAX_HOLD is zero (unlimited hold).
    assign hold_limit = (MAX_HOLD != 0) && (cnt_q == CW'(LIM));

    // Winner search, release decision and next-state computation.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        cand    = '0;
        win     = ptr_q;
        found   = 1'b0;

        // First requester at or after ptr, wrapping modulo 2**N.
        for (int k = 0; k < NR; k++) begin
            cand = ptr_q + N'(k);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end

        rel_now = done || !req[idx_q] || hold_limit;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = BUSY;
                    idx_d        = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    valid_d      = 1'b1;
                    cnt_d        = '0;
                end
            end
            BUSY: begin
                if (rel_now) begin
                    state_d = IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + N'(1);
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin arbiter that shares one downstream resource among 2**N requesters.
- Issues a one-hot grant vector with the same layout a generic N-to-2**N decoder produces, plus the binary grant index and a valid flag.
- Each grant is held until the owner finishes, drops its request, or hits a hold-time limit.
- Sits between requester blocks and a shared datapath, for example a shared bus, display digit, or memory port.

Parameters:
- N, 3, index width; number of requesters = 2**N.
- MAX_HOLD, 8, maximum cycles a grant may be held; 0 = unlimited.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  [0:2**N-1]  request vector; req[i] is requester i (bit 0 is leftmost).
- done  input  1  current owner signals end of transfer; sampled only in BUSY.
- grant  output  [0:2**N-1]  one-hot grant; grant[i] = 1 means requester i owns the resource.
- grant_idx  output  [N-1:0]  binary index of current owner.
- grant_valid  output  1  high while a grant is active.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- All outputs are registered. On reset:
  - state = IDLE
  - grant = all zeros, grant_idx = 0, grant_valid = 0
  - rr pointer ptr = 0, hold counter = 0
- Reset asserted mid-grant: the grant is dropped at the next edge with no completion.
- Invariant: grant_valid = 0 implies grant = 0. grant_valid = 1 implies grant is exactly the one-hot decode of grant_idx.
- Hold counter width is $clog2(MAX_HOLD+1), with minimum 1.
- ptr and all index arithmetic wrap modulo 2**N; ptr = 2**N-1 plus 1 gives 0.

FSM, two states:
- IDLE:
  - If req == 0, stay in IDLE; outputs stay zero.
  - Otherwise pick the winner: the first i with req[i] = 1, searching ptr, ptr+1, ... wrapping modulo 2**N.
  - At the next edge, register grant_idx = winner, grant = onehot(winner), grant_valid = 1, hold counter = 0, and go to BUSY.
  - Request-to-grant latency is 1 cycle.
- BUSY: each cycle, evaluate release = done OR NOT req[grant_idx] OR (MAX_HOLD != 0 AND counter == MAX_HOLD-1).
  - If release is true, at the next edge:
    - grant = 0, grant_valid = 0
    - ptr = grant_idx + 1 (mod 2**N)
    - go to IDLE
  - If release is false, counter increments; it saturates and never wraps.
  - Requests from other requesters while BUSY are ignored; there is no preemption.
- Gap between grants: at least one cycle with grant_valid = 0 always separates consecutive grants, including back-to-back grants to the same requester.
- Grant length: a grant lasts at most MAX_HOLD cycles with grant_valid = 1.

Simultaneous events:
- done and the timeout in the same cycle: a single release occurs; ptr is advanced once.
- done while the owner also keeps req high: the grant is still released. The owner may win again only after all other active requesters, per round-robin.
- Only one requester active: it is re-granted after each one-cycle gap.
- done asserted in IDLE: ignored.
- req changing while in IDLE: only the value sampled at the arbitration edge matters.

Test Plan (N=2, MAX_HOLD=4):
- Reset: hold reset 3 cycles with req=4'b1111 -> grant=0000, grant_valid=0, grant_idx=0 throughout. One cycle after reset falls, grant=1000 and grant_idx=0.
- Rotation: req=1111 held, done pulsed 1 cycle after each grant -> grant sequence 1000, 0100, 0010, 0001, 1000, each separated by exactly one grant_valid=0 cycle.
- Timeout: req=0100 held, done=0 -> grant=0100 high for exactly 4 cycles, 1 cycle low, then re-granted; grant_idx=1 throughout.
- Pointer wrap: ptr=3 after granting requester 2, then req=1001 -> grant goes to idx 3 first, then idx 0.
- Request drop: owner idx 2 deasserts req[2] mid-grant -> grant_valid falls the next cycle; next arbitration starts searching at idx 3.
- Reset mid-grant: assert reset while grant=0010 -> next edge grant=0000, ptr=0. With req=0011 after release, grant=0010 is issued, because the search starts from ptr=0 and finds idx 2 first.
